// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: command encoding and
// round-robin priority state.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_state_t;

    // Only read and write are requests; the unused encoding 11 never competes.
    function automatic logic is_request(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two memory masters, the arbiter and a single-port RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        m0_cmd;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ready;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic [1:0]        m1_cmd;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ready;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        grant;

    modport slave (
        input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_rdata,
        output m0_ready, m0_rvalid, m0_rdata, m1_ready, m1_rvalid, m1_rdata,
        output ram_addr, ram_we, ram_wdata, grant
    );

    modport master (
        output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_rdata,
        input  m0_ready, m0_rvalid, m0_rdata, m1_ready, m1_rvalid, m1_rdata,
        input  ram_addr, ram_we, ram_wdata, grant
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, priority flips to the
// other master after every grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output pri_state_t o_state
);
    pri_state_t r_state;
    pri_state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PRI0;
        else     r_state <= w_next;
    end

    always_comb begin
        o_grant = 2'b00;
        w_next  = r_state;
        case (i_req)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: o_grant = (r_state == PRI0) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
        // The winner hands priority to the other master; idle cycles hold it.
        if (o_grant[0])      w_next = PRI1;
        else if (o_grant[1]) w_next = PRI0;
    end

    assign o_state = r_state;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU (m0) and a loader/debug master (m1) onto one single-port
// RAM, steering read data back one cycle later to whichever master asked.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output pri_state_t     o_pri_state
);
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic [1:0]        w_readGrant;
    logic [1:0]        r_tag;
    logic [ADDR_W-1:0] w_ramAddr;
    logic              w_ramWe;
    logic [DATA_W-1:0] w_ramWdata;

    // Requests are masked during reset so nothing is granted or latched.
    always_comb begin
        w_req[0] = !rst && is_request(bus.m0_cmd);
        w_req[1] = !rst && is_request(bus.m1_cmd);
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_state (o_pri_state)
    );

    always_comb begin
        w_ramAddr  = '0;
        w_ramWe    = 1'b0;
        w_ramWdata = '0;
        if (w_grant[0]) begin
            w_ramAddr  = bus.m0_addr;
            w_ramWe    = (bus.m0_cmd == MEM_WRITE);
            w_ramWdata = bus.m0_wdata;
        end else if (w_grant[1]) begin
            w_ramAddr  = bus.m1_addr;
            w_ramWe    = (bus.m1_cmd == MEM_WRITE);
            w_ramWdata = bus.m1_wdata;
        end
    end

    assign w_readGrant[0] = w_grant[0] && (bus.m0_cmd == MEM_READ);
    assign w_readGrant[1] = w_grant[1] && (bus.m1_cmd == MEM_READ);

    // One-deep return tag: marks which master owns the RAM data next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tag <= 2'b00;
        else     r_tag <= w_readGrant;
    end

    assign bus.grant     = w_grant;
    assign bus.m0_ready  = w_grant[0];
    assign bus.m1_ready  = w_grant[1];
    assign bus.ram_addr  = w_ramAddr;
    assign bus.ram_we    = w_ramWe;
    assign bus.ram_wdata = w_ramWdata;
    assign bus.m0_rvalid = r_tag[0];
    assign bus.m1_rvalid = r_tag[1];
    assign bus.m0_rdata  = r_tag[0] ? bus.ram_rdata : '0;
    assign bus.m1_rdata  = r_tag[1] ? bus.ram_rdata : '0;
endmodule
